// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the write-side CDC arbiters.
package cdc_arb_pkg;

  // Arbiter lock state: IDLE arbitrates per flit, BUSY is locked to one packet owner.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of a requester index; a single requester still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_rr_select.sv
// Rotating-priority selector: grants the first requester found at or after ptr.
module cdc_rr_select
  import cdc_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Walk the requesters starting at ptr and wrapping at N; first hit wins.
  always_comb begin
    logic [IW-1:0] cand;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/cdc_wr_arbiter.sv
// Packet-granular round-robin arbiter in front of a CDC FIFO write port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no packet open; each cycle the rotating selector picks a winner
//   BUSY  | multi-flit packet open; only the owner is served until its last
module cdc_wr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int FLIT_WIDTH = 32,
  localparam int IW        = idx_width(N)
) (
  input  logic                    wr_clk,
  input  logic                    wr_rst,
  input  logic [N*FLIT_WIDTH-1:0] in_flit,
  input  logic [N-1:0]            in_last,
  input  logic [N-1:0]            in_valid,
  output logic [N-1:0]            in_ready,
  output logic [FLIT_WIDTH:0]     wr_data,
  output logic                    wr_inc,
  input  logic                    wr_full,
  output logic                    busy,
  output logic [IW-1:0]           grant_id
);

  arb_state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] grant_nxt;

  logic [N-1:0]  rr_onehot;
  logic [IW-1:0] rr_idx;
  logic          rr_any;

  logic [IW-1:0]         sel_idx;
  logic                  sel_last;
  logic [FLIT_WIDTH-1:0] flit_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_flit
    assign flit_arr[g] = in_flit[g*FLIT_WIDTH +: FLIT_WIDTH];
  end

  cdc_rr_select #(.N(N)) u_rr_select (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .any        (rr_any)
  );

  // State, pointer, owner and grant registers; reset abandons any open packet.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      grant_id <= grant_nxt;
    end
  end

  // Zero-latency select, handshake and write strobe plus next-state decision.
  // in_ready never looks at flit payload, only at valid, full and state.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    grant_nxt  = grant_id;
    sel_idx    = rr_idx;
    in_ready   = '0;

    if (state == BUSY) begin
      sel_idx         = owner;
      in_ready[owner] = ~wr_full;
    end else if (rr_any && !wr_full) begin
      in_ready = rr_onehot;
    end

    if (wr_rst) begin
      in_ready = '0;
    end

    sel_last = in_last[sel_idx];
    wr_inc   = in_valid[sel_idx] & in_ready[sel_idx];
    wr_data  = {sel_last, flit_arr[sel_idx]};

    if (wr_inc) begin
      grant_nxt = sel_idx;
      if (sel_last) begin
        state_nxt = IDLE;
        if (int'(sel_idx) == N - 1) begin
          rr_ptr_nxt = '0;
        end else begin
          rr_ptr_nxt = sel_idx + 1'b1;
        end
      end else begin
        state_nxt = BUSY;
        owner_nxt = sel_idx;
      end
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// Randomised and directed bench for cdc_wr_arbiter with a queue scoreboard.
module tb_cdc_wr_arbiter;

  localparam int N  = 4;
  localparam int FW = 32;
  localparam int IW = 2;

  logic              wr_clk = 1'b0;
  logic              wr_rst;
  logic [N*FW-1:0]   in_flit;
  logic [N-1:0]      in_last, in_valid, in_ready;
  logic [FW:0]       wr_data;
  logic              wr_inc, wr_full, busy;
  logic [IW-1:0]     grant_id;

  logic [FW-1:0]     s_flit;
  logic              s_last, s_valid, s_ready, s_inc, s_full, s_busy;
  logic [FW:0]       s_data;
  logic [0:0]        s_gid;

  logic [FW-1:0]     fl  [N];
  logic              vld [N];
  logic              lst [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign in_flit[g*FW +: FW] = fl[g];
    assign in_valid[g]         = vld[g];
    assign in_last[g]          = lst[g];
  end

  always #5 wr_clk = ~wr_clk;

  cdc_wr_arbiter #(.N(N), .FLIT_WIDTH(FW)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .in_flit(in_flit), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .wr_data(wr_data), .wr_inc(wr_inc),
    .wr_full(wr_full), .busy(busy), .grant_id(grant_id)
  );

  cdc_wr_arbiter #(.N(1), .FLIT_WIDTH(FW)) dut1 (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .in_flit(s_flit), .in_last(s_last),
    .in_valid(s_valid), .in_ready(s_ready), .wr_data(s_data), .wr_inc(s_inc),
    .wr_full(s_full), .busy(s_busy), .grant_id(s_gid)
  );

  typedef struct {
    int            idx;
    logic          last;
    logic [FW-1:0] flit;
  } exp_t;

  exp_t sbq [$];
  exp_t sbq1 [$];

  int errors = 0;
  int checks = 0;
  int n1_writes = 0;

  // Reference: open-packet owner (-1 = none), next-turn index, last grant.
  int m_owner = -1;
  int m_rr    = 0;
  int m_gid   = 0;

  int pend [N];
  int seq  [N];
  logic [N-1:0] en;
  int xfer = -1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Requesters keep valid/data steady while waiting; a new flit appears only after a transfer.
  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      vld[i] = (pend[i] > 0) && (en[i] || (vld[i] && (xfer != i)));
      lst[i] = (pend[i] == 1);
      fl[i]  = {8'(i), 24'(seq[i])};
    end
  endtask

  function automatic int model_pick();
    if (wr_full) return -1;
    if (m_owner >= 0) return vld[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (vld[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_apply(input int p);
    if (p >= 0) begin
      m_gid = p;
      if (lst[p]) begin
        m_owner = -1;
        m_rr    = (p + 1) % N;
      end else begin
        m_owner = p;
      end
      pend[p]--;
      seq[p]++;
    end
  endtask

  // One clock: drive, predict, let the edge pass, then check registered outputs.
  task automatic cycle();
    int p;
    exp_t e;
    drive_srcs();
    p = model_pick();
    if (p >= 0) begin
      e.idx  = p;
      e.last = lst[p];
      e.flit = fl[p];
      sbq.push_back(e);
    end
    #1;
    if (wr_full) chk("ready_while_full", longint'(in_ready), 0);
    @(posedge wr_clk);
    #1;
    xfer = p;
    model_apply(p);
    chk("busy", longint'(busy), (m_owner >= 0) ? 1 : 0);
    chk("grant_id", longint'(grant_id), m_gid);
  endtask

  task automatic drain();
    en      = '1;
    wr_full = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cycle();
    end
  endtask

  // Scoreboard monitor: pops one expected entry per observed write.
  initial begin
    int g, cnt;
    exp_t e;
    forever begin
      @(negedge wr_clk);
      if (wr_inc === 1'b1) begin
        g   = -1;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
          if (in_ready[i]) begin
            g = i;
            cnt++;
          end
        end
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: wr_data=%h ready=%b, no write expected", wr_data, in_ready);
        end else begin
          e = sbq.pop_front();
          if (cnt != 1 || g != e.idx || wr_data !== {e.last, e.flit}) begin
            errors++;
            $display("FAIL write: got req=%0d ready=%b data=%h, expected req=%0d data=%h",
                     g, in_ready, wr_data, e.idx, {e.last, e.flit});
          end
        end
      end
      if (s_inc === 1'b1) begin
        n1_writes++;
        checks++;
        if (sbq1.size() == 0) begin
          errors++;
          $display("FAIL n1_unexpected_write: data=%h", s_data);
        end else begin
          e = sbq1.pop_front();
          if (s_ready !== 1'b1 || s_data !== {e.last, e.flit}) begin
            errors++;
            $display("FAIL n1_write: got data=%h ready=%b, expected data=%h",
                     s_data, s_ready, {e.last, e.flit});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic exp1, busy1;
    exp_t e;

    wr_rst  = 1'b1;
    wr_full = 1'b0;
    en      = '0;
    s_flit  = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    s_full  = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      seq[i]  = 0;
      vld[i]  = 1'b1;
      lst[i]  = 1'b1;
      fl[i]   = '0;
    end
    repeat (2) @(posedge wr_clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_wr_inc", longint'(wr_inc), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_grant_id", longint'(grant_id), 0);
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    wr_rst = 1'b0;

    // All four single-flit every cycle: order 0,1,2,3,0.
    en = '1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) if (pend[i] == 0) pend[i] = 1;
      cycle();
    end
    drain();

    // Requester 1 three-flit packet against a waiting requester 2.
    pend[1] = 3;
    pend[2] = 1;
    en      = 4'b0110;
    repeat (5) cycle();
    drain();

    // Full for three cycles inside a packet.
    pend[0] = 4;
    en      = 4'b0001;
    cycle();
    wr_full = 1'b1;
    repeat (3) cycle();
    wr_full = 1'b0;
    repeat (4) cycle();
    drain();

    // Owner drops valid for two cycles while others wait.
    pend[2] = 3;
    en      = 4'b0100;
    cycle();
    pend[0] = 1;
    pend[1] = 1;
    pend[3] = 1;
    en      = 4'b1011;
    repeat (2) cycle();
    en = 4'b1111;
    repeat (6) cycle();
    drain();

    // Reset mid-packet from requester 3.
    pend[3] = 4;
    en      = 4'b1000;
    repeat (2) cycle();
    drive_srcs();
    #2;
    wr_rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_wr_inc", longint'(wr_inc), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_grant_id", longint'(grant_id), 0);
    @(posedge wr_clk);
    #1;
    m_owner = -1;
    m_rr    = 0;
    m_gid   = 0;
    pend[3] = 0;
    xfer    = -1;
    en      = '0;
    drive_srcs();
    wr_rst = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1;
    en = '1;
    repeat (5) cycle();
    drain();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 3) == 0) pend[i] = int'($urandom_range(1, 4));
        en[i] = ($urandom_range(0, 3) != 0);
      end
      wr_full = ($urandom_range(0, 3) == 0);
      cycle();
    end
    drain();

    // Single-requester instance: five-flit packet with full toggling.
    k     = 0;
    busy1 = 1'b0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      s_full  = ((c % 3) == 1);
      s_valid = 1'b1;
      s_flit  = 32'hA000 + 32'(k);
      s_last  = (k == 4);
      exp1    = !s_full;
      if (exp1) begin
        e.idx  = 0;
        e.last = s_last;
        e.flit = s_flit;
        sbq1.push_back(e);
      end
      @(posedge wr_clk);
      #1;
      if (exp1) begin
        k++;
        busy1 = (k < 5);
      end
      chk("n1_busy", longint'(s_busy), longint'(busy1));
    end
    s_valid = 1'b0;
    s_full  = 1'b0;

    repeat (3) @(posedge wr_clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    chk("n1_scoreboard_empty", sbq1.size(), 0);
    chk("n1_write_count", n1_writes, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
